// File: rtl/mem_arbiter.sv
// Shares one memory port between the instruction fetch unit and the load/store unit.
// One transaction in flight, round-robin on ties, sticky watchdog on a stalled memory response.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    input  logic                ifu_rsp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    input  logic                lsu_rsp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    output logic                mem_rsp_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                timeout_err
);

    localparam int TIMER_W = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
    typedef enum logic {SRC_IFU, SRC_LSU} src_t;

    state_t             state, state_next;
    src_t               owner, last_grant;
    logic [TIMER_W-1:0] timer;
    logic               grant_ifu, grant_lsu;
    logic               rsp_fire, watchdog_fire;

    assign ifu_rdata = mem_rdata;
    assign lsu_rdata = mem_rdata;

    always_comb begin
        state_next    = state;
        grant_ifu     = 1'b0;
        grant_lsu     = 1'b0;
        rsp_fire      = 1'b0;
        watchdog_fire = 1'b0;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        case (state)
            IDLE: begin
                // Readys are gated by reset so nothing is offered while held in reset.
                if (rst) begin
                    grant_ifu = ifu_req_valid && (!lsu_req_valid || last_grant == SRC_LSU);
                    grant_lsu = lsu_req_valid && !grant_ifu;
                end
                ifu_req_ready = grant_ifu;
                lsu_req_ready = grant_lsu;
                if (grant_ifu || grant_lsu) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_next = RSP;
                end
            end
            RSP: begin
                if (owner == SRC_IFU) begin
                    ifu_rsp_valid = mem_rsp_valid;
                    mem_rsp_ready = ifu_rsp_ready;
                end else begin
                    lsu_rsp_valid = mem_rsp_valid;
                    mem_rsp_ready = lsu_rsp_ready;
                end
                rsp_fire      = mem_rsp_valid && mem_rsp_ready;
                // A response handshake on the deadline cycle takes priority over the abort.
                watchdog_fire = (TIMEOUT != 0) && (timer == TIMER_W'(TIMEOUT)) && !rsp_fire;
                if (rsp_fire || watchdog_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            owner       <= SRC_IFU;
            last_grant  <= SRC_LSU;
            timer       <= '0;
            timeout_err <= 1'b0;
            mem_addr    <= '0;
            mem_wen     <= 1'b0;
            mem_wdata   <= '0;
            mem_wmask   <= '0;
        end else begin
            state <= state_next;
            if (grant_ifu) begin
                mem_addr   <= ifu_addr;
                mem_wen    <= 1'b0;
                mem_wdata  <= '0;
                mem_wmask  <= '0;
                owner      <= SRC_IFU;
                last_grant <= SRC_IFU;
            end else if (grant_lsu) begin
                mem_addr   <= lsu_addr;
                mem_wen    <= lsu_wen;
                mem_wdata  <= lsu_wdata;
                mem_wmask  <= lsu_wmask;
                owner      <= SRC_LSU;
                last_grant <= SRC_LSU;
            end
            // Timer restarts on every entry into RSP and only runs while waiting there.
            if (state == REQ) begin
                timer <= '0;
            end else if (state == RSP && TIMEOUT != 0) begin
                timer <= timer + TIMER_W'(1);
            end
            if (watchdog_fire) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a short watchdog (TIMEOUT=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled away from edges.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives the memory side of a transaction from REQ through to the response handshake.
    task automatic finish_mem(input logic [31:0] rdata);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = rdata;
        step();
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        ifu_req_valid = 0; ifu_addr = 0; ifu_rsp_ready = 1;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; lsu_rsp_ready = 1;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
        #3;
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_mem_rsp_ready", mem_rsp_ready, 1'b0);
        check("rst_fields", {mem_wen, mem_wmask, mem_addr, mem_wdata}, 69'd0);
        check("rst_timeout_err", timeout_err, 1'b0);
        step();
        rst = 1'b1;

        // Tie right after reset: IFU first, then alternation while both stay valid.
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        lsu_req_valid = 1; lsu_addr = 32'h0000_0100; lsu_wen = 0;
        #1;
        check("tie1_ifu_ready", ifu_req_ready, 1'b1);
        check("tie1_lsu_ready", lsu_req_ready, 1'b0);
        step();
        check("tie1_addr", mem_addr, 32'h8000_0000);
        check("tie1_no_grant_in_req", {ifu_req_ready, lsu_req_ready}, 2'b00);
        finish_mem(32'h1111_1111);
        check("tie2_ifu_ready", ifu_req_ready, 1'b0);
        check("tie2_lsu_ready", lsu_req_ready, 1'b1);
        step();
        check("tie2_addr", mem_addr, 32'h0000_0100);
        finish_mem(32'h2222_2222);
        check("tie3_ifu_ready", ifu_req_ready, 1'b1);
        check("tie3_lsu_ready", lsu_req_ready, 1'b0);
        ifu_req_valid = 0; lsu_req_valid = 0;

        // IFU-only fetch; mem_req_valid rises the cycle after acceptance.
        step();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        #1;
        check("fetch_ready", ifu_req_ready, 1'b1);
        check("fetch_mem_valid_early", mem_req_valid, 1'b0);
        step();
        ifu_req_valid = 0;
        check("fetch_mem_valid", mem_req_valid, 1'b1);
        check("fetch_fields", {mem_wen, mem_wmask, mem_addr, mem_wdata}, {1'b0, 4'h0, 32'h8000_0000, 32'h0});
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        mem_rsp_valid = 1; mem_rdata = 32'h0000_0413;
        #1;
        check("fetch_ifu_rsp_valid", ifu_rsp_valid, 1'b1);
        check("fetch_ifu_rdata", ifu_rdata, 32'h0000_0413);
        check("fetch_lsu_rsp_valid", lsu_rsp_valid, 1'b0);
        check("fetch_mem_rsp_ready", mem_rsp_ready, 1'b1);
        step();
        mem_rsp_valid = 0;
        check("fetch_back_idle", mem_req_valid, 1'b0);

        // LSU store with memory stalled 5 cycles; a waiting IFU request must not be granted.
        lsu_req_valid = 1; lsu_addr = 32'h8000_0100; lsu_wen = 1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        #1;
        check("store_ready", lsu_req_ready, 1'b1);
        step();
        lsu_req_valid = 0; lsu_addr = 32'h1234_5678; lsu_wdata = 32'h0; lsu_wmask = 4'h0; lsu_wen = 0;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0200;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("store_stall%0d_fields", i),
                  {mem_req_valid, mem_wen, mem_wmask, mem_addr, mem_wdata},
                  {1'b1, 1'b1, 4'hF, 32'h8000_0100, 32'hDEAD_BEEF});
            check($sformatf("store_stall%0d_no_grant", i), {ifu_req_ready, lsu_req_ready}, 2'b00);
            step();
        end
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        mem_rsp_valid = 1; mem_rdata = 32'hCAFE_0000;
        lsu_rsp_ready = 0;
        #1;
        check("store_ack_valid", lsu_rsp_valid, 1'b1);
        check("store_ack_not_ifu", ifu_rsp_valid, 1'b0);
        check("store_backpressure", mem_rsp_ready, 1'b0);
        step();
        lsu_rsp_ready = 1;
        #1;
        check("store_rsp_ready", mem_rsp_ready, 1'b1);
        step();
        mem_rsp_valid = 0;
        check("waiting_ifu_granted", ifu_req_ready, 1'b1);
        step();
        ifu_req_valid = 0;
        check("waiting_ifu_addr", mem_addr, 32'h8000_0200);

        // Watchdog: no response, abort after timer reaches 4 in RSP.
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        repeat (4) step();
        check("wd_not_yet", timeout_err, 1'b0);
        check("wd_still_rsp", mem_rsp_ready, 1'b1);
        step();
        check("wd_fired", timeout_err, 1'b1);
        check("wd_idle", mem_rsp_ready, 1'b0);
        check("wd_no_ifu_rsp", ifu_rsp_valid, 1'b0);

        // Next grant after abort, then reset in the middle of its RSP phase.
        lsu_req_valid = 1; lsu_addr = 32'h8000_0300; lsu_wen = 0;
        #1;
        check("wd_next_ready", lsu_req_ready, 1'b1);
        step();
        lsu_req_valid = 0;
        check("wd_next_addr", mem_addr, 32'h8000_0300);
        check("wd_sticky", timeout_err, 1'b1);
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        mem_rsp_valid = 1; mem_rdata = 32'h0BAD_F00D;
        ifu_req_valid = 1; lsu_req_valid = 1;
        #1;
        check("pre_rst_lsu_rsp", lsu_rsp_valid, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_rst_outputs",
              {mem_req_valid, mem_rsp_ready, lsu_rsp_valid, ifu_rsp_valid, ifu_req_ready, lsu_req_ready},
              6'b000000);
        check("mid_rst_fields", {mem_wen, mem_wmask, mem_addr, mem_wdata}, 69'd0);
        check("mid_rst_timeout_err", timeout_err, 1'b0);
        step();
        mem_rsp_valid = 0;
        rst = 1'b1;
        #1;
        check("post_rst_tie_ifu", ifu_req_ready, 1'b1);
        check("post_rst_tie_lsu", lsu_req_ready, 1'b0);
        ifu_req_valid = 0; lsu_req_valid = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
